// File: rtl/y_alu.sv
// Registered 32-bit ALU: AND, OR, ADD, SUB and signed SLT behind one shared adder.
// Outputs change only on a rising clk edge or on an asynchronous rst.
module y_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             ex
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             slt;
  logic [WIDTH-1:0] z_d;

  // op[2] selects subtraction for both SUB and SLT: a + ~b + 1.
  assign sub   = op[2];
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

  // Signed overflow: like-signed addends producing a sum of the opposite sign.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign slt = sum[WIDTH-1] ^ ovf;

  always_comb begin
    z_d = '0;
    case (op)
      OpAnd:   z_d = a & b;
      OpOr:    z_d = a | b;
      OpAdd:   z_d = sum;
      OpSub:   z_d = sum;
      OpSlt:   z_d = {{(WIDTH-1){1'b0}}, slt};
      default: z_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z  <= '0;
      ex <= 1'b1;
    end else begin
      z  <= z_d;
      ex <= (z_d == '0);
    end
  end

endmodule

// File: tb/tb_y_alu.sv
// Directed self-checking bench for y_alu: reset, logic, arithmetic wrap, SLT extremes,
// undefined ops and a short randomized sweep against a behavioural reference.
module tb_y_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] z;
  logic        ex;

  int unsigned n_checks;
  int unsigned n_errors;

  y_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .z   (z),
    .ex  (ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (a=%h b=%h op=%b)", tag, got, exp, a, b, op);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [2:0] vop, input logic [31:0] exp_z);
    @(negedge clk);
    a  = va;
    b  = vb;
    op = vop;
    @(posedge clk);
    #1;
    check({tag, ".z"}, z, exp_z);
    check({tag, ".ex"}, {31'd0, ex}, {31'd0, exp_z == 32'd0});
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] va, input logic [31:0] vb,
                                            input logic [2:0] vop);
    case (vop)
      3'b000:  return va & vb;
      3'b001:  return va | vb;
      3'b010:  return va + vb;
      3'b110:  return va - vb;
      3'b111:  return ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [2:0] ops [5];
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    a   = 32'd5;
    b   = 32'd3;
    op  = 3'b010;
    #1 rst = 1'b1;
    #1;
    check("rst_async.z", z, 32'd0);
    check("rst_async.ex", {31'd0, ex}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held.z", z, 32'd0);
    check("rst_held.ex", {31'd0, ex}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release.z", z, 32'd0);
    @(posedge clk);
    #1;
    check("after_rst.z", z, 32'd8);
    check("after_rst.ex", {31'd0, ex}, 32'd0);

    // Mid-stream reset clears outputs without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.z", z, 32'd0);
    check("rst_mid.ex", {31'd0, ex}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    apply("and", 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0);
    apply("or",  32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0);
    apply("add_wrap", 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0);
    apply("add", 32'd100, 32'd23, 3'b010, 32'd123);
    apply("sub_eq", 32'd7, 32'd7, 3'b110, 32'd0);
    apply("sub_wrap", 32'd0, 32'd1, 3'b110, 32'hFFFFFFFF);
    apply("slt_neg", 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1);
    apply("slt_maxmin", 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'd0);
    apply("slt_minmax", 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1);
    apply("slt_eq", 32'd5, 32'd5, 3'b111, 32'd0);
    apply("slt_pos", 32'd3, 32'd9, 3'b111, 32'd1);
    apply("undef_011", 32'hDEADBEEF, 32'h12345678, 3'b011, 32'd0);
    apply("undef_100", 32'hCAFEF00D, 32'h0F0F0F0F, 3'b100, 32'd0);
    apply("undef_101", 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b101, 32'd0);

    ops[0] = 3'b000;
    ops[1] = 3'b001;
    ops[2] = 3'b010;
    ops[3] = 3'b110;
    ops[4] = 3'b111;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) begin
        ra = $urandom;
        rb = $urandom;
        apply("rand", ra, rb, ops[k], ref_model(ra, rb, ops[k]));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
